// File: rtl/key_schedule_80_pkg.sv
// Shared constants, FSM state type and PRESENT S-box table for the key schedule
// and the encrypt datapath.
package key_schedule_80_pkg;

    localparam int unsigned KEY_SIZE   = 80;
    localparam int unsigned SIZE       = 64;
    localparam int unsigned NUM_ROUNDS = 31;
    localparam int unsigned NUM_KEYS   = NUM_ROUNDS + 1;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned RC_W       = 5;
    localparam int unsigned RC_LSB     = 15;
    localparam int unsigned ROT_AMT    = 61;
    localparam int unsigned SBOX_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_e;

    // Nibble i of this constant is S(i): 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/present_sbox.sv
// Combinational 4-bit PRESENT S-box.
module present_sbox
    import key_schedule_80_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] sub_c
);

    always_comb begin
        sub_c = sbox_lookup(nib);
    end

endmodule

// File: rtl/key_schedule_80.sv
// PRESENT-80 key schedule: expands a master key into 32 round keys held in a
// flop table, one key per clock, readable combinationally at any time.
module key_schedule_80
    import key_schedule_80_pkg::*;
#(
    parameter int unsigned KEY_SIZE   = key_schedule_80_pkg::KEY_SIZE,
    parameter int unsigned SIZE       = key_schedule_80_pkg::SIZE,
    parameter int unsigned NUM_ROUNDS = key_schedule_80_pkg::NUM_ROUNDS
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic [KEY_SIZE-1:0] key_in,
    output logic                busy,
    output logic                done,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [SIZE-1:0]     rd_key
);

    localparam int unsigned N_KEYS = NUM_ROUNDS + 1;

    ks_state_e           state_q, state_d;
    logic [KEY_SIZE-1:0] k_q, k_d;
    logic [RC_W-1:0]     rc_q, rc_d;
    logic [SIZE-1:0]     tbl_q [N_KEYS];
    logic [SIZE-1:0]     tbl_d [N_KEYS];
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [KEY_SIZE-1:0] k_rot;
    logic [KEY_SIZE-1:0] k_next;
    logic [SBOX_W-1:0]   sbox_out;

    // Rotate left by 61, S-box the top nibble, fold the round counter in
    assign k_rot = {k_q[KEY_SIZE-ROT_AMT-1:0], k_q[KEY_SIZE-1:KEY_SIZE-ROT_AMT]};

    present_sbox u_sbox (
        .nib   (k_rot[KEY_SIZE-1 -: SBOX_W]),
        .sub_c (sbox_out)
    );

    always_comb begin
        k_next                        = k_rot;
        k_next[KEY_SIZE-1 -: SBOX_W]  = sbox_out;
        k_next[RC_LSB +: RC_W]        = k_rot[RC_LSB +: RC_W] ^ rc_q;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rc_d    = rc_q;
        tbl_d   = tbl_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_GEN;
                    k_d      = key_in;
                    tbl_d[0] = key_in[KEY_SIZE-1 -: SIZE];
                    rc_d     = RC_W'(1);
                end
            end
            ST_GEN: begin
                k_d         = k_next;
                tbl_d[rc_q] = k_next[KEY_SIZE-1 -: SIZE];
                // rc stops at the last round so it never wraps inside one expansion
                if (rc_q == RC_W'(NUM_ROUNDS)) begin
                    state_d = ST_DONE;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_GEN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            rc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tbl_q   <= tbl_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rd_key = tbl_q[rd_idx];

endmodule
